fdiv_fsqrt_rs: RTL and testbench
================================

FDIV_FSQRT_RS -- requirements
Module: fdiv_fsqrt_rs

Interface
REQ-001 Parameter N_ENTRY, default 4, reservation-station depth (2..16).
REQ-002 Parameter LATENCY, default 3, pipeline stages from dispatch to result (1..8).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  misprediction flush, synchronous, active-high.
REQ-006 issue_valid / issue_ready  input / output  1 / 1  issue handshake.
REQ-007 issue_op  input  fdiv_or_fsqrt_t  FDIV or FSQRT.
REQ-008 issue_tag  input  ROB_WIDTH  destination ROB tag.
REQ-009 fpr_read[1:0]  input  cdb_t  operands {valid, tag, data}; valid=0 means waiting on tag.
REQ-010 fpr_cdb  input  cdb_t  broadcast result used for operand wakeup.
REQ-011 cdb_req_valid / cdb_req_ready  output / input  1 / 1  result-bus request handshake.
REQ-012 result_tag / result_data  output  ROB_WIDTH / 32  result presented while cdb_req_valid=1.

Function
REQ-013 Entries SHALL be kept compacted: index 0 oldest, valid entries contiguous from 0; count 0..N_ENTRY.
REQ-014 Issue fires when issue_valid && issue_ready && !flush; the new entry is written at index count (after removal-shift if an entry is dispatched that cycle).
REQ-015 issue_ready SHALL equal (count < N_ENTRY) || dispatch in the same cycle; combinational, no dependence on issue_valid.
REQ-016 On issue, operand j is ready if fpr_read[j].valid, or if fpr_cdb.valid && fpr_cdb.tag == fpr_read[j].tag (data taken from fpr_cdb); both true is illegal and flagged by an assertion.
REQ-017 For FSQRT, operand 1 SHALL be marked ready unconditionally; its data is don't-care.
REQ-018 Each cycle every waiting operand whose tag matches a valid fpr_cdb SHALL become ready with fpr_cdb.data at the next edge.
REQ-019 Dispatch selects the lowest-index entry with both operands ready (oldest-ready first), only when pipeline stage 1 can accept (REQ-021); the remaining entries shift down to preserve order.
REQ-020 An entry becomes dispatchable no earlier than the cycle after it is written or woken (no same-cycle issue-to-dispatch).
REQ-021 Pipeline: LATENCY stages, each {valid, tag, op, operands}; whole pipeline advances when stage LATENCY is empty or (cdb_req_valid && cdb_req_ready); otherwise all stages hold.
REQ-022 cdb_req_valid = stage LATENCY valid; result_tag/result_data from that stage, result_data selects fdiv or fsqrt core output by op.
REQ-023 Latency: issue at cycle t with ready operands, empty station and no stall -> dispatch at t+1 -> cdb_req_valid at t+LATENCY+1.
REQ-024 Throughput: one dispatch and one result per cycle sustained when cdb_req_ready=1.
REQ-025 Flush: at the next edge all entries and all pipeline valids clear, count=0; issue in the flush cycle is dropped; a result handshake in the flush cycle still completes.
REQ-026 Simultaneous issue + dispatch at count==N_ENTRY SHALL be accepted with no loss or duplication.

Reset
REQ-027 While reset_n=0: all entry and pipeline valids 0, count 0, cdb_req_valid 0, issue_ready 1; data/tag fields need not reset.
REQ-028 Reset assertion mid-operation discards all entries and in-flight results immediately; first issue accepted at first edge after deassertion.

Structure
REQ-029 ROB_WIDTH, cdb_t, fdiv_or_fsqrt_t and function tag_match SHALL live in the shared package; N_ENTRY/LATENCY are module parameters.
REQ-030 The stallable datapath SHALL be sub-module fdiv_fsqrt_pipe (stages, valid/stall logic, fdiv_core/fsqrt_core instances); fdiv_fsqrt_rs holds the entry array, wakeup, select and issue logic.

Verification
REQ-031 Reset release, issue FDIV tag 5, a=0x40C00000, b=0x40000000 ready, cdb_req_ready=1 -> cdb_req_valid at t+4 (LATENCY=3), result_tag 5, result_data 0x40400000.
REQ-032 Issue FSQRT tag 2 with opd0 waiting tag 9; two cycles later fpr_cdb {1,9,0x41800000} -> result_tag 2, result_data 0x40800000, dispatched cycle after wakeup.
REQ-033 Fill 4 entries (tags 1..4), only tag 3 ready -> tag 3 dispatched first, issue_ready 1 next cycle, order 1,2,4 preserved.
REQ-034 Hold cdb_req_ready=0 for 10 cycles with 8 ready issues -> exactly LATENCY+N_ENTRY accepted, issue_ready 0, no result lost or duplicated after release.
REQ-035 Flush with 3 entries and 2 in flight -> next cycle cdb_req_valid 0, count 0, no stale tag ever presented.
REQ-036 reset_n pulsed low mid-stream for 1 cycle -> all outputs at reset values asynchronously, clean operation after.

Source files
------------

// File: rtl/fdiv_fsqrt_rs_pkg.sv
// Shared types for the FP divide/square-root reservation station:
// ROB tag width, CDB/operand bus, op select, entry and pipeline stage records.
package fdiv_fsqrt_rs_pkg;

  localparam int ROB_WIDTH = 5;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic {
    OP_FDIV  = 1'b0,
    OP_FSQRT = 1'b1
  } fdiv_or_fsqrt_t;

  // valid=1 means data holds the value; valid=0 means still waiting on tag
  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  typedef struct packed {
    fdiv_or_fsqrt_t       op;
    logic [ROB_WIDTH-1:0] rob_tag;
    cdb_t                 opd0;
    cdb_t                 opd1;
  } rs_entry_t;

  typedef struct packed {
    logic                 valid;
    fdiv_or_fsqrt_t       op;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          a;
    logic [31:0]          b;
  } pipe_stage_t;

  function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] tag);
    return bus.valid && (bus.tag == tag);
  endfunction

endpackage

// File: rtl/fdiv_fsqrt_rs_pipe.sv
// Stallable execution pipeline plus the combinational divide and square-root
// cores evaluated on the final stage. Cores handle normal operands and truncate.
module fdiv_core
  import fdiv_fsqrt_rs_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  logic              sign;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic [47:0]       num;
  logic [23:0]       mb;
  logic [24:0]       quo;
  logic signed [9:0] exp_s;

  always_comb begin
    sign  = a[31] ^ b[31];
    ea    = a[30:23];
    eb    = b[30:23];
    num   = {1'b1, a[22:0], 24'd0};
    mb    = {1'b1, b[22:0]};
    // quotient of two [1,2) mantissas lies in (0.5,2): bit 24 says which half
    quo   = 25'(num / {24'd0, mb});
    exp_s = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126 + $signed({9'd0, quo[24]});
    q     = {sign, exp_s[7:0], quo[24] ? quo[23:1] : quo[22:0]};
    if (ea == 8'd0) begin
      q = {sign, 31'd0};
    end else if (eb == 8'd0 || exp_s >= 10'sd255) begin
      q = {sign, 8'hFF, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      q = {sign, 31'd0};
    end
  end
endmodule

module fsqrt_core
  import fdiv_fsqrt_rs_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] r
);
  logic [7:0]  ea;
  logic [47:0] rad;

  function automatic logic [22:0] sqrt_frac(input logic [47:0] x);
    logic [26:0] rem;
    logic [26:0] trial;
    logic [23:0] root;
    rem  = '0;
    root = '0;
    for (int i = 23; i >= 0; i--) begin
      rem   = {rem[24:0], x[2*i +: 2]};
      trial = {1'b0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[22:0], 1'b1};
      end else begin
        root = {root[22:0], 1'b0};
      end
    end
    return root[22:0];
  endfunction

  always_comb begin
    ea  = a[30:23];
    // odd biased exponent means even unbiased exponent: no extra mantissa doubling
    rad = ea[0] ? {1'b0, 1'b1, a[22:0], 23'd0} : {1'b1, a[22:0], 24'd0};
    r   = {1'b0, 8'(({1'b0, ea} + 9'd127) >> 1), sqrt_frac(rad)};
    if (ea == 8'd0) begin
      r = {a[31], 31'd0};
    end else if (a[31]) begin
      r = FP_QNAN;
    end
  end
endmodule

module fdiv_fsqrt_pipe
  import fdiv_fsqrt_rs_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  fdiv_or_fsqrt_t       in_op,
  input  logic [ROB_WIDTH-1:0] in_tag,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  output logic                 in_ready,
  output logic                 cdb_req_valid,
  input  logic                 cdb_req_ready,
  output logic [ROB_WIDTH-1:0] result_tag,
  output logic [31:0]          result_data
);
  pipe_stage_t stg_q [LATENCY];
  pipe_stage_t stg_d [LATENCY];
  logic        advance;
  logic [31:0] div_res;
  logic [31:0] sqrt_res;

  // the whole pipe moves together; it only holds when the last stage is blocked
  assign advance       = !stg_q[LATENCY-1].valid || cdb_req_ready;
  assign in_ready      = advance;
  assign cdb_req_valid = stg_q[LATENCY-1].valid;
  assign result_tag    = stg_q[LATENCY-1].tag;
  assign result_data   = (stg_q[LATENCY-1].op == OP_FSQRT) ? sqrt_res : div_res;

  always_comb begin
    for (int i = 0; i < LATENCY; i++) stg_d[i] = stg_q[i];
    if (advance) begin
      stg_d[0] = '{valid: in_valid, op: in_op, tag: in_tag, a: in_a, b: in_b};
      for (int i = 1; i < LATENCY; i++) stg_d[i] = stg_q[i-1];
    end
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) stg_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) stg_q[i] <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  fdiv_core u_fdiv (
    .a (stg_q[LATENCY-1].a),
    .b (stg_q[LATENCY-1].b),
    .q (div_res)
  );

  fsqrt_core u_fsqrt (
    .a (stg_q[LATENCY-1].a),
    .r (sqrt_res)
  );
endmodule

// File: rtl/fdiv_fsqrt_rs.sv
// Compacted reservation station for FDIV/FSQRT: operand capture and CDB wakeup,
// oldest-ready select with shift-down removal, feeding the stallable pipe.
module fdiv_fsqrt_rs
  import fdiv_fsqrt_rs_pkg::*;
#(
  parameter int N_ENTRY = 4,
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  fdiv_or_fsqrt_t       issue_op,
  input  logic [ROB_WIDTH-1:0] issue_tag,
  input  cdb_t [1:0]           fpr_read,
  input  cdb_t                 fpr_cdb,
  output logic                 cdb_req_valid,
  input  logic                 cdb_req_ready,
  output logic [ROB_WIDTH-1:0] result_tag,
  output logic [31:0]          result_data
);
  localparam int CNT_W = $clog2(N_ENTRY + 1);
  localparam int IDX_W = $clog2(N_ENTRY);

  rs_entry_t          ent_q [N_ENTRY];
  rs_entry_t          ent_d [N_ENTRY];
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   base;
  logic [N_ENTRY-1:0] ready_vec;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               dispatch;
  logic               issue_fire;
  logic               pipe_in_ready;
  cdb_t               new_opd [2];
  rs_entry_t          new_ent;
  logic [1:0]         opd_conflict;

  // readiness comes from registered state only, so a freshly written or
  // freshly woken entry cannot dispatch before the following cycle
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      ready_vec[i] = (CNT_W'(i) < count_q) && ent_q[i].opd0.valid && ent_q[i].opd1.valid;
    end
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign dispatch    = sel_found && pipe_in_ready;
  assign issue_ready = (count_q < CNT_W'(N_ENTRY)) || dispatch;
  assign issue_fire  = issue_valid && issue_ready && !flush;

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      new_opd[j]      = fpr_read[j];
      opd_conflict[j] = fpr_read[j].valid && tag_match(fpr_cdb, fpr_read[j].tag);
      if (!fpr_read[j].valid && tag_match(fpr_cdb, fpr_read[j].tag)) begin
        new_opd[j] = '{valid: 1'b1, tag: fpr_read[j].tag, data: fpr_cdb.data};
      end
    end
    new_ent = '{op: issue_op, rob_tag: issue_tag, opd0: new_opd[0], opd1: new_opd[1]};
    // square root has a single source; the second slot never waits
    if (issue_op == OP_FSQRT) begin
      new_ent.opd1.valid = 1'b1;
      opd_conflict[1]    = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) ent_d[i] = ent_q[i];
    if (dispatch) begin
      for (int i = 0; i < N_ENTRY - 1; i++) begin
        if (i >= int'(sel_idx)) ent_d[i] = ent_q[i+1];
      end
    end
    for (int i = 0; i < N_ENTRY; i++) begin
      if (!ent_d[i].opd0.valid && tag_match(fpr_cdb, ent_d[i].opd0.tag)) begin
        ent_d[i].opd0.valid = 1'b1;
        ent_d[i].opd0.data  = fpr_cdb.data;
      end
      if (!ent_d[i].opd1.valid && tag_match(fpr_cdb, ent_d[i].opd1.tag)) begin
        ent_d[i].opd1.valid = 1'b1;
        ent_d[i].opd1.data  = fpr_cdb.data;
      end
    end
    base    = count_q - CNT_W'(dispatch);
    count_d = base;
    if (issue_fire) begin
      ent_d[IDX_W'(base)] = new_ent;
      count_d             = base + CNT_W'(1);
    end
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // payload only; occupancy is defined entirely by count_q
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  a_no_double_source : assert property (
    @(posedge clk) disable iff (!reset_n) !(issue_fire && (|opd_conflict))
  );

  fdiv_fsqrt_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (dispatch),
    .in_op         (ent_q[sel_idx].op),
    .in_tag        (ent_q[sel_idx].rob_tag),
    .in_a          (ent_q[sel_idx].opd0.data),
    .in_b          (ent_q[sel_idx].opd1.data),
    .in_ready      (pipe_in_ready),
    .cdb_req_valid (cdb_req_valid),
    .cdb_req_ready (cdb_req_ready),
    .result_tag    (result_tag),
    .result_data   (result_data)
  );
endmodule

// File: tb/tb_fdiv_fsqrt_rs.sv
// Directed bench for fdiv_fsqrt_rs (N_ENTRY=4, LATENCY=3) with hand-computed
// IEEE single results and an in-order result scoreboard.
module tb_fdiv_fsqrt_rs;
  import fdiv_fsqrt_rs_pkg::*;

  localparam int N_ENTRY = 4;
  localparam int LATENCY = 3;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 flush = 1'b0;
  logic                 issue_valid = 1'b0;
  logic                 issue_ready;
  fdiv_or_fsqrt_t       issue_op = OP_FDIV;
  logic [ROB_WIDTH-1:0] issue_tag = '0;
  cdb_t [1:0]           fpr_read = '0;
  cdb_t                 fpr_cdb = '0;
  logic                 cdb_req_valid;
  logic                 cdb_req_ready = 1'b0;
  logic [ROB_WIDTH-1:0] result_tag;
  logic [31:0]          result_data;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int tstart = 0;
  int accepted = 0;
  int stale = 0;
  logic [ROB_WIDTH+31:0] exp_q[$];
  logic [ROB_WIDTH+31:0] got_q[$];
  int got_cyc_q[$];
  logic [31:0] dvals [8];

  fdiv_fsqrt_rs #(.N_ENTRY(N_ENTRY), .LATENCY(LATENCY)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_tag     (issue_tag),
    .fpr_read      (fpr_read),
    .fpr_cdb       (fpr_cdb),
    .cdb_req_valid (cdb_req_valid),
    .cdb_req_ready (cdb_req_ready),
    .result_tag    (result_tag),
    .result_data   (result_data)
  );

  // clock / cycle count / result capture
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (reset_n && cdb_req_valid && cdb_req_ready) begin
      got_q.push_back({result_tag, result_data});
      got_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive_issue(input fdiv_or_fsqrt_t op, input logic [ROB_WIDTH-1:0] tag,
                             input cdb_t o0, input cdb_t o1);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_tag   = tag;
    fpr_read[0] = o0;
    fpr_read[1] = o1;
  endtask

  function automatic cdb_t rdy(input logic [31:0] d);
    return '{valid: 1'b1, tag: '0, data: d};
  endfunction

  function automatic cdb_t wait_on(input logic [ROB_WIDTH-1:0] t);
    return '{valid: 1'b0, tag: t, data: 32'd0};
  endfunction

  // scoreboard: wait (bounded) for n results, confirm no extras, compare in order
  task automatic drain(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    repeat (LATENCY + 2) tick();
    check("result_count", got_q.size(), n);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check("result_tag_data", got_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    dvals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40C00000, 32'h41000000, 32'h41100000, 32'h41800000};

    // reset values
    repeat (3) @(posedge clk);
    #2;
    check("rst_cdb_valid", cdb_req_valid, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_count", dut.count_q, 0);
    reset_n = 1'b1;
    cdb_req_ready = 1'b1;

    // 6.0 / 2.0, result exactly LATENCY+1 cycles after issue
    drive_issue(OP_FDIV, 5, rdy(32'h40C00000), rdy(32'h40000000));
    #1 check("a_issue_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    for (int k = 1; k <= LATENCY; k++) begin
      check("a_not_early", cdb_req_valid, 0);
      tick();
    end
    check("a_valid", cdb_req_valid, 1);
    check("a_tag", result_tag, 5);
    check("a_data", result_data, 32'h40400000);
    exp_q.push_back({5'd5, 32'h40400000});
    drain(1, 10);

    // back-to-back: 1/3 (truncated), sqrt 2 (truncated), sqrt 9
    got_cyc_q.delete();
    drive_issue(OP_FDIV, 11, rdy(32'h3F800000), rdy(32'h40400000));
    tick();
    drive_issue(OP_FSQRT, 12, rdy(32'h40000000), wait_on(31));
    tick();
    drive_issue(OP_FSQRT, 13, rdy(32'h41100000), wait_on(31));
    tick();
    issue_valid = 1'b0;
    exp_q.push_back({5'd11, 32'h3EAAAAAA});
    exp_q.push_back({5'd12, 32'h3FB504F3});
    exp_q.push_back({5'd13, 32'h40400000});
    drain(3, 20);
    check("tp_cycle1", got_cyc_q[1] - got_cyc_q[0], 1);
    check("tp_cycle2", got_cyc_q[2] - got_cyc_q[0], 2);

    // FSQRT waiting on tag 9, woken two cycles after issue
    got_cyc_q.delete();
    drive_issue(OP_FSQRT, 2, wait_on(9), wait_on(31));
    tstart = cyc;
    tick();
    issue_valid = 1'b0;
    tick();
    fpr_cdb = '{valid: 1'b1, tag: 5'd9, data: 32'h41800000};
    tick();
    fpr_cdb = '0;
    tick();
    tick();
    check("b_not_early", cdb_req_valid, 0);
    tick();
    check("b_valid", cdb_req_valid, 1);
    check("b_tag", result_tag, 2);
    check("b_data", result_data, 32'h40800000);
    exp_q.push_back({5'd2, 32'h40800000});
    drain(1, 10);
    check("b_cycle", got_cyc_q[0] - tstart, 6);

    // fill with tags 1..4, only tag 3 ready; the rest share wakeup tag 20
    drive_issue(OP_FDIV, 1, wait_on(20), rdy(32'h40000000));
    tick();
    drive_issue(OP_FDIV, 2, wait_on(20), rdy(32'h40800000));
    tick();
    drive_issue(OP_FDIV, 3, rdy(32'h41000000), rdy(32'h40000000));
    tick();
    drive_issue(OP_FDIV, 4, wait_on(20), rdy(32'h3FC00000));
    #1 check("c_ready_full_issue", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    check("c_ready_after", issue_ready, 1);
    check("c_count", dut.count_q, 3);
    check("c_order0", dut.ent_q[0].rob_tag, 1);
    check("c_order1", dut.ent_q[1].rob_tag, 2);
    check("c_order2", dut.ent_q[2].rob_tag, 4);
    fpr_cdb = '{valid: 1'b1, tag: 5'd20, data: 32'h41400000};
    tick();
    fpr_cdb = '0;
    exp_q.push_back({5'd3, 32'h40800000});
    exp_q.push_back({5'd1, 32'h40C00000});
    exp_q.push_back({5'd2, 32'h40400000});
    exp_q.push_back({5'd4, 32'h41000000});
    drain(4, 30);

    // back-pressure: 10 cycles with cdb_req_ready=0, up to 8 ready issues
    cdb_req_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      if (accepted < 8) begin
        drive_issue(OP_FDIV, ROB_WIDTH'(10 + accepted), rdy(dvals[accepted]), rdy(32'h3F800000));
      end
      #1;
      if (issue_valid && issue_ready) begin
        exp_q.push_back({ROB_WIDTH'(10 + accepted), dvals[accepted]});
        accepted++;
      end
      tick();
    end
    #1;
    check("d_accepted", accepted, LATENCY + N_ENTRY);
    check("d_issue_ready", issue_ready, 0);
    check("d_count", dut.count_q, N_ENTRY);
    issue_valid = 1'b0;
    cdb_req_ready = 1'b1;
    drain(LATENCY + N_ENTRY, 40);

    // flush with 3 waiting entries and 2 operations in flight
    drive_issue(OP_FDIV, 26, wait_on(30), rdy(32'h3F800000));
    tick();
    drive_issue(OP_FDIV, 27, wait_on(30), rdy(32'h3F800000));
    tick();
    drive_issue(OP_FDIV, 28, wait_on(30), rdy(32'h3F800000));
    tick();
    drive_issue(OP_FDIV, 24, rdy(32'h40000000), rdy(32'h3F800000));
    tick();
    drive_issue(OP_FDIV, 25, rdy(32'h40400000), rdy(32'h3F800000));
    tick();
    issue_valid = 1'b0;
    tick();
    check("e_count_pre", dut.count_q, 3);
    flush = 1'b1;
    drive_issue(OP_FDIV, 29, rdy(32'h40000000), rdy(32'h3F800000));
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    check("e_cdb_valid", cdb_req_valid, 0);
    check("e_count", dut.count_q, 0);
    check("e_issue_ready", issue_ready, 1);
    fpr_cdb = '{valid: 1'b1, tag: 5'd30, data: 32'h40000000};
    tick();
    fpr_cdb = '0;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      if (cdb_req_valid) stale++;
      tick();
    end
    check("e_stale_cycles", stale, 0);
    check("e_no_results", got_q.size(), 0);

    // asynchronous reset pulse while a result is presented
    drive_issue(OP_FDIV, 14, rdy(32'h40000000), rdy(32'h3F800000));
    tick();
    drive_issue(OP_FDIV, 15, rdy(32'h40400000), rdy(32'h3F800000));
    tick();
    issue_valid = 1'b0;
    cdb_req_ready = 1'b0;
    tick();
    tick();
    check("f_pre_valid", cdb_req_valid, 1);
    reset_n = 1'b0;
    #1;
    check("f_rst_valid", cdb_req_valid, 0);
    check("f_rst_ready", issue_ready, 1);
    check("f_rst_count", dut.count_q, 0);
    tick();
    reset_n = 1'b1;
    cdb_req_ready = 1'b1;
    drive_issue(OP_FDIV, 7, rdy(32'h41100000), rdy(32'h40400000));
    exp_q.push_back({5'd7, 32'h40400000});
    tick();
    issue_valid = 1'b0;
    drain(1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
